// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg -- shared state encoding, width defaults and helpers for the fetch sequencer.
// Rev 1.0
`default_nettype none

package pc_ctrl_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] pc_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int          PC_W_DEF     = 64;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  // A transaction or an undelivered instruction is owned by the block.
  function automatic logic st_busy(input pc_state_t st);
    return (st == ST_REQ) || (st == ST_WAIT) || (st == ST_HOLD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// pc_next_calc -- combinational next-PC arithmetic: sequential increment and branch target.
// Rev 1.0
`default_nettype none

module pc_next_calc
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_inst_pc,
  input  logic            i_br_rel,
  input  logic [PC_W-1:0] i_br_target,
  output logic [PC_W-1:0] o_pc_inc,
  output logic [PC_W-1:0] o_br_tgt
);

  logic [PC_W-1:0] w_tgt_abs;
  logic [PC_W-1:0] w_tgt_rel;

  // All sums wrap modulo 2^PC_W; a negative offset is just its two's complement.
  assign o_pc_inc  = i_pc + PC_W'(1);
  assign w_tgt_abs = i_br_target;
  assign w_tgt_rel = i_inst_pc + i_br_target;
  assign o_br_tgt  = i_br_rel ? w_tgt_rel : w_tgt_abs;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- fetch sequencer owning the PC; single-outstanding imem handshake feeding decode.
// Rev 1.0
`default_nettype none

module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  input  logic              i_br_valid,
  input  logic              i_br_rel,
  input  logic [PC_W-1:0]   i_br_target,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst_data,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic              o_busy
);

  pc_state_t         r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_br_pend;
  logic [PC_W-1:0]   r_br_tgt;
  logic              r_halt_pend;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst_data;
  logic [PC_W-1:0]   r_inst_pc;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_br_tgt;
  logic              w_redirect;
  logic [PC_W-1:0]   w_redir_tgt;
  logic              w_halt;

  pc_next_calc #(
    .PC_W (PC_W)
  ) u_next (
    .i_pc        (r_pc),
    .i_inst_pc   (r_inst_pc),
    .i_br_rel    (i_br_rel),
    .i_br_target (i_br_target),
    .o_pc_inc    (w_pc_inc),
    .o_br_tgt    (w_br_tgt)
  );

  // A redirect arriving in the same cycle as the response beats any older pending one.
  assign w_redirect  = i_br_valid | r_br_pend;
  assign w_redir_tgt = i_br_valid ? w_br_tgt : r_br_tgt;
  assign w_halt      = i_halt_req | r_halt_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_br_pend    <= 1'b0;
      r_br_tgt     <= '0;
      r_halt_pend  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (i_br_valid) begin
            r_pc <= w_br_tgt;
          end
          if (i_start) begin
            r_state <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (i_br_valid) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= w_br_tgt;
          end
          if (i_halt_req) begin
            r_halt_pend <= 1'b1;
          end
          if (i_imem_gnt) begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (i_imem_rvalid) begin
            if (w_redirect) begin
              // Response belongs to the old stream: drop it and refetch at the target.
              r_pc        <= w_redir_tgt;
              r_br_pend   <= 1'b0;
              r_halt_pend <= 1'b0;
              r_state     <= w_halt ? ST_HALTED : ST_REQ;
            end else begin
              r_inst_data  <= i_imem_rdata;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= w_pc_inc;
              r_halt_pend  <= w_halt;
              r_state      <= ST_HOLD;
            end
          end else begin
            if (i_br_valid) begin
              r_br_pend <= 1'b1;
              r_br_tgt  <= w_br_tgt;
            end
            if (i_halt_req) begin
              r_halt_pend <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (i_br_valid || i_inst_ready) begin
            r_inst_valid <= 1'b0;
            if (i_br_valid) begin
              r_pc <= w_br_tgt;
            end
            r_br_pend   <= 1'b0;
            r_halt_pend <= 1'b0;
            r_state     <= w_halt ? ST_HALTED : ST_REQ;
          end else if (i_halt_req) begin
            r_halt_pend <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_imem_req   = (r_state == ST_REQ);
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_inst_data  = r_inst_data;
  assign o_inst_pc    = r_inst_pc;
  assign o_busy       = st_busy(r_state);

endmodule

`default_nettype wire
